// File: rtl/xdisplay_scan.sv
// Memory-mapped, time-multiplexed N-digit 7-segment scanner with per-digit
// segment registers, refresh prescaler, dead-time blanking and a status register.
module xdisplay_scan #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 3,
  parameter int N_DIGITS    = 4,
  parameter int SEG_W       = 8,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 16,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sel,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          data_in,
  output logic [DATA_W-1:0]          data_out,
  output logic [N_DIGITS+SEG_W-1:0]  display_out
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int OUT_W = N_DIGITS + SEG_W;
  localparam logic [OUT_W-1:0] OFF_LEVEL = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  logic [SEG_W-1:0]    seg_r [N_DIGITS];
  logic [1:0]          ctrl_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [IDX_W-1:0]    idx_r;

  logic                wr_s;
  logic                ctrl_wr_s;
  logic                clear_s;
  logic                wrap_s;
  logic                in_dead_s;
  logic                dead_s;
  logic                lit_s;
  logic [SEG_W-1:0]    seg_sel_s;
  logic [SEG_W-1:0]    seg_rd_s;
  logic [N_DIGITS-1:0] digit_s;
  logic [OUT_W-1:0]    drive_s;
  logic [OUT_W-1:0]    display_d_s;
  logic [DATA_W-1:0]   status_s;
  logic                unused_s;

  assign wr_s      = sel & we;
  assign ctrl_wr_s = wr_s && (addr == ADDR_W'(N_DIGITS));
  // A CTRL write clearing EN takes priority over the wrap advance on the same edge.
  assign clear_s   = !ctrl_r[0] || (ctrl_wr_s && !data_in[0]);
  assign wrap_s    = (cnt_r == CNT_W'(REFRESH_DIV - 1));
  assign in_dead_s = (cnt_r < CNT_W'(DEAD_CYCLES));
  assign dead_s    = ctrl_r[0] & in_dead_s;
  assign lit_s     = ctrl_r[0] & ~ctrl_r[1] & ~in_dead_s;
  assign status_s  = DATA_W'({dead_s, 5'b00000, 3'(idx_r)});
  assign unused_s  = ^data_in;

  // Segment and control register writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_DIGITS; k++) begin
        seg_r[k] <= '0;
      end
      ctrl_r <= 2'b01;
    end else begin
      for (int k = 0; k < N_DIGITS; k++) begin
        if (wr_s && (addr == ADDR_W'(k))) begin
          seg_r[k] <= data_in[SEG_W-1:0];
        end
      end
      if (ctrl_wr_s) begin
        ctrl_r <= data_in[1:0];
      end
    end
  end

  // Refresh prescaler and digit index.
  always_ff @(posedge clk) begin
    if (rst || clear_s) begin
      cnt_r <= '0;
      idx_r <= '0;
    end else if (wrap_s) begin
      cnt_r <= '0;
      idx_r <= (idx_r == IDX_W'(N_DIGITS - 1)) ? '0 : idx_r + IDX_W'(1);
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Slot drive: select digit and segments, then apply output polarity.
  always_comb begin
    seg_sel_s = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      seg_sel_s = seg_sel_s | ((idx_r == IDX_W'(k)) ? seg_r[k] : '0);
    end
    digit_s = N_DIGITS'(1'b1) << idx_r;
    if (lit_s) begin
      drive_s = {digit_s, seg_sel_s};
    end else begin
      drive_s = '0;
    end
    display_d_s = (ACTIVE_LOW != 0) ? ~drive_s : drive_s;
  end

  // Registered pin drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      display_out <= OFF_LEVEL;
    end else begin
      display_out <= display_d_s;
    end
  end

  // Read mux; zero when not selected so the decoder can OR bus slaves together.
  always_comb begin
    seg_rd_s = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      seg_rd_s = seg_rd_s | ((addr == ADDR_W'(k)) ? seg_r[k] : '0);
    end
    if (!(sel && !we)) begin
      data_out = '0;
    end else if (addr == ADDR_W'(N_DIGITS)) begin
      data_out = DATA_W'(ctrl_r);
    end else if (addr == ADDR_W'(N_DIGITS + 1)) begin
      data_out = status_s;
    end else begin
      data_out = DATA_W'(seg_rd_s);
    end
  end

endmodule
